add_arbiter: RTL and testbench

Round-robin arbiter that shares one registered 16-bit adder between several requesters in the ALU. Each requester presents an operand pair over a valid/ready handshake. The block grants at most one requester per cycle and performs the addition in a single registered stage. It returns the sum, carry-out and the winner's ID through a one-entry output register with backpressure.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/add_arbiter.sv | 83 ++++++++
 tb/tb_add_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, ID-width helper and the adder response record.
package alu_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int ALU_ID_MAX_W = 3;

  // Width of a requester index; never below one bit so a 1-bit port stays legal.
  function automatic int clog2_id(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

  typedef struct packed {
    logic [ALU_WIDTH-1:0]    sum;
    logic                    carry;
    logic [ALU_ID_MAX_W-1:0] id;
  } add_resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority select: searches upward from a rotating pointer and
// moves the pointer one past the winner whenever a grant is consumed.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = clog2_id(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             enable,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic             w_found;
  logic [IDX_W-1:0] w_idx;
  int               w_pos;

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_pos   = 0;
    for (int k = 0; k < N; k++) begin
      w_pos = (int'(r_ptr) + k) % N;
      if (!w_found && req[w_pos]) begin
        w_found = 1'b1;
        w_idx   = IDX_W'(w_pos);
      end
    end
  end

  assign grant     = (w_found && enable) ? (N'(1) << w_idx) : '0;
  assign grant_idx = w_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= (w_idx == IDX_W'(N - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// Shares one registered WIDTH+1-bit adder among N_REQ requesters; the result
// sits in a one-entry output register that can be drained and refilled in the same cycle.
module add_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = ALU_WIDTH,
  parameter int ID_W  = clog2_id(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WIDTH-1:0]       resp_sum,
  output logic                   resp_carry,
  output logic [ID_W-1:0]        resp_id
);

  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_idx;
  logic             w_slot_free;
  logic             w_enable;
  logic             w_xfer;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;

  logic             r_vld;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [ID_W-1:0]  r_id;

  // Grants are suppressed while reset is held so nothing is handed out mid-reset.
  assign w_slot_free = !r_vld || resp_ready;
  assign w_enable    = w_slot_free && !rst;
  assign w_xfer      = |(req_valid & w_grant);

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .enable    (w_enable),
    .advance   (w_xfer),
    .grant     (w_grant),
    .grant_idx (w_idx)
  );

  assign req_ready = w_grant;

  assign w_a   = req_a[int'(w_idx) * WIDTH +: WIDTH];
  assign w_b   = req_b[int'(w_idx) * WIDTH +: WIDTH];
  assign w_sum = {1'b0, w_a} + {1'b0, w_b};

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld   <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_id    <= '0;
    end else if (w_xfer) begin
      r_vld   <= 1'b1;
      r_sum   <= w_sum[WIDTH-1:0];
      r_carry <= w_sum[WIDTH];
      r_id    <= w_idx;
    end else if (resp_ready) begin
      r_vld   <= 1'b0;
    end
  end

  assign resp_valid = r_vld;
  assign resp_sum   = r_sum;
  assign resp_carry = r_carry;
  assign resp_id    = r_id;

endmodule

// File: tb/tb_add_arbiter.sv
// Scoreboard bench for add_arbiter: a reference model predicts grants and
// queues expected sums; the held output is compared against the queue head.
module tb_add_arbiter;
  import alu_pkg::*;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     req_ready;
  logic             resp_valid;
  logic             resp_ready;
  logic [W-1:0]     resp_sum;
  logic             resp_carry;
  logic [IW-1:0]    resp_id;

  add_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_carry (resp_carry),
    .resp_id    (resp_id)
  );

  always #5 clk = ~clk;

  int        checks   = 0;
  int        failures = 0;
  add_resp_t sb[$];
  int        ids[$];
  int        m_ptr;
  logic      m_vld;
  logic [N-1:0] keep;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i]     = 1'b1;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
  endtask

  // One clock: entered and left just after a falling edge.
  task automatic cycle();
    int        g;
    int        p;
    logic      sf;
    logic [N-1:0] exp_rdy;
    add_resp_t r;
    #1;
    sf = !m_vld || resp_ready;
    g  = -1;
    if (sf && !rst) begin
      for (int k = 0; k < N; k++) begin
        p = (m_ptr + k) % N;
        if (g < 0 && req_valid[p]) g = p;
      end
    end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("resp_valid", 32'(resp_valid), 32'(m_vld));
    if (m_vld && sb.size() > 0) begin
      chk("resp_sum", 32'(resp_sum), 32'(sb[0].sum));
      chk("resp_carry", 32'(resp_carry), 32'(sb[0].carry));
      chk("resp_id", 32'(resp_id), 32'(sb[0].id));
    end
    if (resp_valid && resp_ready) ids.push_back(int'(resp_id));
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      m_vld = 1'b0;
      m_ptr = 0;
    end else begin
      if (m_vld && resp_ready && sb.size() > 0) void'(sb.pop_front());
      if (g >= 0) begin
        {r.carry, r.sum} = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]};
        r.id = 3'(g);
        sb.push_back(r);
        m_ptr = (g + 1) % N;
        if (keep[g]) set_req(g, W'($urandom), W'($urandom));
        else req_valid[g] = 1'b0;
      end
      m_vld = (g >= 0) || (m_vld && !resp_ready);
    end
    @(negedge clk);
  endtask

  initial begin
    int h;
    logic [W-1:0] frozen_sum;
    logic [IW-1:0] frozen_id;
    rst = 1'b1; resp_ready = 1'b1; keep = '0;
    req_valid = '0; req_a = '0; req_b = '0;
    m_ptr = 0; m_vld = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, W'(16'h0010 * (i + 1)), W'(i + 1));
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_sum", 32'(resp_sum), 32'h0);
    chk("rst_resp_carry", 32'(resp_carry), 32'h0);
    chk("rst_resp_id", 32'(resp_id), 32'h0);

    // release reset; first grant must be requester 0, then drain the rest
    rst = 1'b0;
    #1;
    chk("first_grant", 32'(req_ready), 32'h1);
    for (int c = 0; c < 6; c++) cycle();

    // single add
    set_req(0, 16'h0003, 16'h0004);
    cycle();
    #1;
    chk("single_sum", 32'(resp_sum), 32'h7);
    chk("single_carry", 32'(resp_carry), 32'h0);
    chk("single_id", 32'(resp_id), 32'h0);
    cycle();

    // overflow
    set_req(2, 16'hFFFF, 16'h0001);
    cycle();
    #1;
    chk("ovf_sum", 32'(resp_sum), 32'h0);
    chk("ovf_carry", 32'(resp_carry), 32'h1);
    chk("ovf_id", 32'(resp_id), 32'h2);
    cycle();

    // bring pointer back to 0, then round-robin stream
    set_req(3, 16'h1234, 16'h4321);
    cycle();
    cycle();
    keep = '1;
    for (int i = 0; i < N; i++) set_req(i, W'($urandom), W'($urandom));
    ids.delete();
    for (int c = 0; c < 9; c++) cycle();
    chk("rr_count", 32'(ids.size()), 32'd8);
    for (int k = 0; k < ids.size(); k++) chk("rr_order", 32'(ids[k]), 32'(k % N));

    // backpressure for three cycles
    resp_ready = 1'b0;
    #1;
    frozen_sum = resp_sum;
    frozen_id  = resp_id;
    h = int'(resp_id);
    for (int c = 0; c < 3; c++) begin
      cycle();
      #1;
      chk("stall_sum", 32'(resp_sum), 32'(frozen_sum));
      chk("stall_id", 32'(resp_id), 32'(frozen_id));
    end
    resp_ready = 1'b1;
    ids.delete();
    for (int c = 0; c < 5; c++) cycle();
    chk("resume_count", 32'(ids.size()), 32'd5);
    for (int k = 0; k < ids.size(); k++) chk("resume_order", 32'(ids[k]), 32'((h + k) % N));

    // reset mid-stream, asynchronous
    #1;
    chk("pre_rst_valid", 32'(resp_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(resp_valid), 32'h0);
    chk("arst_sum", 32'(resp_sum), 32'h0);
    chk("arst_id", 32'(resp_id), 32'h0);
    chk("arst_ready", 32'(req_ready), 32'h0);
    sb.delete(); m_vld = 1'b0; m_ptr = 0;
    cycle();
    rst = 1'b0;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'h1);
    for (int c = 0; c < 6; c++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
